// File: rtl/mips64_pkg.sv
// Shared definitions for the 64-bit datapath: narrowing mode encoding,
// skid-buffer occupancy states and saturation constant helpers.
package mips64_pkg;

  localparam int MAX_W = 64;

  typedef enum logic {
    NARROW_TRUNC = 1'b0,
    NARROW_SAT   = 1'b1
  } narrow_mode_e;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  // Most positive signed value of width w, zero-extended to MAX_W bits.
  function automatic logic [MAX_W-1:0] SAT_MAX(input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Most negative signed value of width w, zero-extended to MAX_W bits.
  function automatic logic [MAX_W-1:0] SAT_MIN(input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i == w - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sign_narrow_if.sv
// Valid/ready bundle for the narrowing stage, plus the overflow counter
// status and clear. The slave modport is the stage, master is its user.
interface sign_narrow_if #(
  parameter int SIZE_IN  = 64,
  parameter int SIZE_OUT = 32,
  parameter int CNT_W    = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [SIZE_IN-1:0]  in_data;
  logic                in_sat;
  logic                out_valid;
  logic                out_ready;
  logic [SIZE_OUT-1:0] out_data;
  logic                out_ovf;
  logic [CNT_W-1:0]    ovf_count;
  logic                cnt_clr;

  modport master (
    output in_valid, in_data, in_sat, out_ready, cnt_clr,
    input  in_ready, out_valid, out_data, out_ovf, ovf_count
  );

  modport slave (
    input  in_valid, in_data, in_sat, out_ready, cnt_clr,
    output in_ready, out_valid, out_data, out_ovf, ovf_count
  );
endinterface

// File: rtl/skid_buffer.sv
// Generic 2-entry valid/ready register slice. The main entry drives the
// output; the skid entry catches a word arriving while the output stalls.
// in_ready is a flop so upstream never sees a path from out_ready.
module skid_buffer
  import mips64_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  state, state_next;
  logic [W-1:0] main_q, skid_q;
  logic         push, pop;
  logic         load_main_in, load_main_skid, load_skid;

  assign out_valid = (state != SKID_EMPTY);
  assign out_data  = main_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Occupancy transitions; a push never meets a full buffer because
  // in_ready is low whenever the skid entry is occupied.
  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      SKID_EMPTY: begin
        if (push) begin
          state_next   = SKID_ONE;
          load_main_in = 1'b1;
        end
      end
      SKID_ONE: begin
        if (push && pop) begin
          load_main_in = 1'b1;
        end else if (push) begin
          state_next = SKID_FULL;
          load_skid  = 1'b1;
        end else if (pop) begin
          state_next = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (pop) begin
          state_next     = SKID_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_next = SKID_EMPTY;
    endcase
  end

  // Occupancy register and the registered ready derived from next occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SKID_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_next;
      in_ready <= (state_next != SKID_FULL);
    end
  end

  // Entry storage; the skid word moves forward when the main word leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_data;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_data;
    end
  end

endmodule

// File: rtl/sign_narrow.sv
// Narrows a signed SIZE_IN-bit value to SIZE_OUT bits, flags signed
// overflow, optionally saturates, and counts overflows (sticky at max).
// Result is registered through a 2-entry skid buffer.
module sign_narrow
  import mips64_pkg::*;
#(
  parameter int SIZE_IN  = 64,
  parameter int SIZE_OUT = 32,
  parameter int CNT_W    = 16
) (
  input  logic clk,
  input  logic rst_n,
  sign_narrow_if.slave bus
);

  if (SIZE_OUT >= SIZE_IN || SIZE_OUT > MAX_W) begin : g_bad_width
    $error("sign_narrow: SIZE_OUT must be smaller than SIZE_IN and at most MAX_W");
  end

  localparam logic [MAX_W-1:0] MIN_FULL = SAT_MIN(SIZE_OUT);
  localparam logic [MAX_W-1:0] MAX_FULL = SAT_MAX(SIZE_OUT);

  logic [SIZE_IN-SIZE_OUT:0] upper;
  logic                      ovf;
  logic                      accept;
  logic [SIZE_OUT-1:0]       narrowed;
  logic [SIZE_OUT:0]         entry_out;

  // The value fits when every bit from the output sign bit upward agrees.
  assign upper  = bus.in_data[SIZE_IN-1:SIZE_OUT-1];
  assign ovf    = !((&upper) || (~|upper));
  assign accept = bus.in_valid & bus.in_ready;

  // Pick the wrapped low bits or the saturation limit matching the input sign.
  always_comb begin
    narrowed = bus.in_data[SIZE_OUT-1:0];
    if (ovf && (bus.in_sat == NARROW_SAT)) begin
      narrowed = bus.in_data[SIZE_IN-1] ? MIN_FULL[SIZE_OUT-1:0] : MAX_FULL[SIZE_OUT-1:0];
    end
  end

  skid_buffer #(.W(SIZE_OUT + 1)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   ({narrowed, ovf}),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (entry_out)
  );

  assign bus.out_data = entry_out[SIZE_OUT:1];
  assign bus.out_ovf  = entry_out[0];

  // Sticky overflow counter; clear wins over a simultaneous overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ovf_count <= '0;
    end else if (bus.cnt_clr) begin
      bus.ovf_count <= '0;
    end else if (accept && ovf && (bus.ovf_count != '1)) begin
      bus.ovf_count <= bus.ovf_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sign_narrow.sv
// Directed and random checks of sign_narrow: reset, narrowing rules,
// backpressure, simultaneous events, counter limit and a model soak.
module tb_sign_narrow;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  sign_narrow_if #(.SIZE_IN(64), .SIZE_OUT(32), .CNT_W(16)) bus ();
  sign_narrow_if #(.SIZE_IN(64), .SIZE_OUT(32), .CNT_W(2))  bus2 ();

  sign_narrow #(.SIZE_IN(64), .SIZE_OUT(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  sign_narrow #(.SIZE_IN(64), .SIZE_OUT(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task applyStimulus(input logic v, input logic [63:0] d, input logic s);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_sat   = s;
  endtask

  // Independent reference: fits when sign-extending the truncation gives x back.
  function automatic logic [32:0] model(input logic [63:0] x, input logic s);
    logic [31:0] t;
    logic [63:0] sx;
    logic        o;
    t  = x[31:0];
    sx = {{32{t[31]}}, t};
    o  = (sx != x);
    if (o && s) t = x[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return {o, t};
  endfunction

  task test_reset;
    rst_n = 1'b0;
    applyStimulus(1'b0, 64'h0, 1'b0);
    bus.out_ready = 1'b0; bus.cnt_clr = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.in_sat = 1'b0;
    bus2.out_ready = 1'b0; bus2.cnt_clr = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_out_data got=%h exp=0", bus.out_data); end
    checks++; if (bus.out_ovf !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_ovf got=%b exp=0", bus.out_ovf); end
    checks++; if (bus.ovf_count !== 16'h0) begin failures++; $display("[TB] FAIL reset_ovf_count got=%0d exp=0", bus.ovf_count); end
    checks++; if (bus2.ovf_count !== 2'h0) begin failures++; $display("[TB] FAIL reset_ovf_count2 got=%0d exp=0", bus2.ovf_count); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task test_in_range;
    bus.out_ready = 1'b1;
    applyStimulus(1'b1, 64'hFFFF_FFFF_8000_0000, 1'b1);
    @(negedge clk);
    checks++; if ({bus.out_valid, bus.out_ovf, bus.out_data} !== {1'b1, 1'b0, 32'h8000_0000}) begin failures++;
      $display("[TB] FAIL in_range_min got v=%b o=%b d=%h exp v=1 o=0 d=80000000", bus.out_valid, bus.out_ovf, bus.out_data); end
    applyStimulus(1'b1, 64'h0000_0000_7FFF_FFFF, 1'b0);
    @(negedge clk);
    checks++; if ({bus.out_valid, bus.out_ovf, bus.out_data} !== {1'b1, 1'b0, 32'h7FFF_FFFF}) begin failures++;
      $display("[TB] FAIL in_range_max got v=%b o=%b d=%h exp v=1 o=0 d=7fffffff", bus.out_valid, bus.out_ovf, bus.out_data); end
    applyStimulus(1'b0, 64'h0, 1'b0);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL in_range_drain got=%b exp=0", bus.out_valid); end
  endtask

  task test_overflow;
    logic [63:0] vin [3];
    logic        vsat [3];
    logic [31:0] vexp [3];
    vin[0] = 64'h0000_0001_0000_0005; vsat[0] = 1'b0; vexp[0] = 32'h0000_0005;
    vin[1] = 64'h0000_0001_0000_0005; vsat[1] = 1'b1; vexp[1] = 32'h7FFF_FFFF;
    vin[2] = 64'h8000_0000_0000_0000; vsat[2] = 1'b1; vexp[2] = 32'h8000_0000;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, vin[i], vsat[i]);
      @(negedge clk);
      checks++; if ({bus.out_valid, bus.out_ovf, bus.out_data} !== {1'b1, 1'b1, vexp[i]}) begin failures++;
        $display("[TB] FAIL overflow_%0d got v=%b o=%b d=%h exp v=1 o=1 d=%h", i, bus.out_valid, bus.out_ovf, bus.out_data, vexp[i]); end
    end
    applyStimulus(1'b0, 64'h0, 1'b0);
    @(negedge clk);
    checks++; if (bus.ovf_count !== 16'd3) begin failures++; $display("[TB] FAIL overflow_count got=%0d exp=3", bus.ovf_count); end
  endtask

  task test_backpressure;
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 64'h0000_0000_0000_0005, 1'b0);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_ready_one got=%b exp=1", bus.in_ready); end
    applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_ready_full got=%b exp=0", bus.in_ready); end
    applyStimulus(1'b1, 64'h0000_0001_0000_0007, 1'b0);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_ready_held got=%b exp=0", bus.in_ready); end
    checks++; if ({bus.out_valid, bus.out_ovf, bus.out_data} !== {1'b1, 1'b0, 32'h0000_0005}) begin failures++;
      $display("[TB] FAIL bp_hold_first got v=%b o=%b d=%h exp v=1 o=0 d=00000005", bus.out_valid, bus.out_ovf, bus.out_data); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if ({bus.out_valid, bus.out_ovf, bus.out_data} !== {1'b1, 1'b0, 32'hFFFF_FFFE}) begin failures++;
      $display("[TB] FAIL bp_second got v=%b o=%b d=%h exp v=1 o=0 d=fffffffe", bus.out_valid, bus.out_ovf, bus.out_data); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_ready_reopen got=%b exp=1", bus.in_ready); end
    @(negedge clk);
    checks++; if ({bus.out_valid, bus.out_ovf, bus.out_data} !== {1'b1, 1'b1, 32'h0000_0007}) begin failures++;
      $display("[TB] FAIL bp_third got v=%b o=%b d=%h exp v=1 o=1 d=00000007", bus.out_valid, bus.out_ovf, bus.out_data); end
    applyStimulus(1'b0, 64'h0, 1'b0);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_no_duplicate got=%b exp=0", bus.out_valid); end
    checks++; if (bus.ovf_count !== 16'd4) begin failures++; $display("[TB] FAIL bp_count got=%0d exp=4", bus.ovf_count); end
  endtask

  task test_simultaneous;
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 64'h0000_0000_0000_0011, 1'b0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    applyStimulus(1'b1, 64'h0000_0000_0000_0022, 1'b0);
    @(negedge clk);
    checks++; if ({bus.out_valid, bus.out_data} !== {1'b1, 32'h0000_0022}) begin failures++;
      $display("[TB] FAIL simul_swap got v=%b d=%h exp v=1 d=00000022", bus.out_valid, bus.out_data); end
    bus.out_ready = 1'b0;
    applyStimulus(1'b0, 64'h0, 1'b0);
    @(negedge clk);
    checks++; if ({bus.out_valid, bus.in_ready, bus.out_data} !== {1'b1, 1'b1, 32'h0000_0022}) begin failures++;
      $display("[TB] FAIL simul_occ_one got v=%b r=%b d=%h exp v=1 r=1 d=00000022", bus.out_valid, bus.in_ready, bus.out_data); end
    bus.out_ready = 1'b1;
    bus.cnt_clr = 1'b1;
    applyStimulus(1'b1, 64'h0000_0002_0000_0000, 1'b1);
    @(negedge clk);
    bus.cnt_clr = 1'b0;
    checks++; if (bus.ovf_count !== 16'd0) begin failures++; $display("[TB] FAIL simul_clr_priority got=%0d exp=0", bus.ovf_count); end
    checks++; if ({bus.out_valid, bus.out_ovf, bus.out_data} !== {1'b1, 1'b1, 32'h7FFF_FFFF}) begin failures++;
      $display("[TB] FAIL simul_clr_data got v=%b o=%b d=%h exp v=1 o=1 d=7fffffff", bus.out_valid, bus.out_ovf, bus.out_data); end
    applyStimulus(1'b0, 64'h0, 1'b0);
    @(negedge clk);
  endtask

  task test_counter_limit;
    int exp_cnt;
    bus2.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus2.in_valid = 1'b1;
      bus2.in_data  = 64'hF000_0000_0000_0000 + 64'(i);
      bus2.in_sat   = 1'b0;
      @(negedge clk);
      exp_cnt = (i + 1 > 3) ? 3 : i + 1;
      checks++; if (bus2.ovf_count !== 2'(exp_cnt)) begin failures++;
        $display("[TB] FAIL counter_limit_%0d got=%0d exp=%0d", i, bus2.ovf_count, exp_cnt); end
    end
    bus2.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task test_reset_midstream;
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 64'h0000_0001_0000_0000, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 64'h0000_0000_0000_0003, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 64'h0, 1'b0);
    checks++; if ({bus.in_ready, bus.ovf_count} !== {1'b0, 16'd1}) begin failures++;
      $display("[TB] FAIL midrst_prefill got r=%b c=%0d exp r=0 c=1", bus.in_ready, bus.ovf_count); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL midrst_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.ovf_count !== 16'd0) begin failures++; $display("[TB] FAIL midrst_count got=%0d exp=0", bus.ovf_count); end
    checks++; if (bus2.ovf_count !== 2'd0) begin failures++; $display("[TB] FAIL midrst_count2 got=%0d exp=0", bus2.ovf_count); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task test_random_soak;
    logic [32:0] expq [$];
    logic [32:0] exp_e;
    logic [63:0] d;
    logic [63:0] corners [6];
    int          sent;
    int          got;
    corners[0] = 64'h0000_0000_7FFF_FFFF; corners[1] = 64'h0000_0000_8000_0000;
    corners[2] = 64'hFFFF_FFFF_8000_0000; corners[3] = 64'hFFFF_FFFF_7FFF_FFFF;
    corners[4] = 64'h7FFF_FFFF_FFFF_FFFF; corners[5] = 64'h8000_0000_0000_0000;
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 320; cyc++) begin
      case ($urandom_range(0, 3))
        0: d = {$urandom, $urandom};
        1: d = {33'h0, 31'($urandom)};
        2: d = {33'h1_FFFF_FFFF, 31'($urandom)};
        default: d = corners[$urandom_range(0, 5)];
      endcase
      applyStimulus(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (bus.out_valid && bus.out_ready) begin
        exp_e = (expq.size() > 0) ? expq.pop_front() : 33'bx;
        got++;
        checks++; if ({bus.out_ovf, bus.out_data} !== exp_e) begin failures++;
          $display("[TB] FAIL soak_out_%0d got o=%b d=%h exp o=%b d=%h", got, bus.out_ovf, bus.out_data, exp_e[32], exp_e[31:0]); end
      end
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(model(bus.in_data, bus.in_sat));
        sent++;
      end
      @(negedge clk);
    end
    applyStimulus(1'b0, 64'h0, 1'b0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (bus.out_valid) begin
        exp_e = (expq.size() > 0) ? expq.pop_front() : 33'bx;
        got++;
        checks++; if ({bus.out_ovf, bus.out_data} !== exp_e) begin failures++;
          $display("[TB] FAIL soak_drain_%0d got o=%b d=%h exp o=%b d=%h", got, bus.out_ovf, bus.out_data, exp_e[32], exp_e[31:0]); end
      end
      @(negedge clk);
    end
    checks++; if (got !== sent || expq.size() != 0) begin failures++;
      $display("[TB] FAIL soak_count got=%0d exp=%0d left=%0d", got, sent, expq.size()); end
  endtask

  initial begin
    test_reset();
    test_in_range();
    test_overflow();
    test_backpressure();
    test_simultaneous();
    test_counter_limit();
    test_reset_midstream();
    test_random_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
